// File: rtl/cache_bus_pkg.sv
// Shared types and fixed AXI burst encodings for the cache line bus master.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB,
    StDone
  } bus_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [7:0] LEN_LINE   = 8'd15;

  localparam int unsigned LINE_DATA_WIDTH  = 64;
  localparam int unsigned LINE_BEATS_DEF   = 16;
  localparam int unsigned LINE_WIDTH       = LINE_DATA_WIDTH * LINE_BEATS_DEF;
  localparam int unsigned LINE_OFFSET_BITS = $clog2(LINE_WIDTH / 8);

endpackage

// File: rtl/bus_arbiter.sv
// Fixed-priority grant: the lowest requesting index wins.
module bus_arbiter #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned IDX_WIDTH = 1
) (
  input  logic [N_CLIENTS-1:0] req,
  output logic [N_CLIENTS-1:0] grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 any_req
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Walk downwards so the lowest index overrides any higher one.
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/cache_memory_bus.sv
// Shared AXI4 master turning per-client line refills/write-backs into INCR bursts,
// plus a free-running ACE snoop-to-invalidate path.
module cache_memory_bus
  import cache_bus_pkg::*;
#(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = LINE_DATA_WIDTH,
  parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [N_CLIENTS-1:0]                      command_valid,
  input  logic [N_CLIENTS-1:0]                      command_store,
  input  logic [N_CLIENTS-1:0]                      command_rready,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]           command_addr,
  input  logic [N_CLIENTS*DATA_WIDTH*LINE_BEATS-1:0] data_in,
  output logic [N_CLIENTS-1:0]                      bus_ready,
  output logic [N_CLIENTS-1:0]                      bus_valid,
  output logic [DATA_WIDTH*LINE_BEATS-1:0]          data_out,
  output logic                                      invalidate,
  output logic [ADDR_WIDTH-1:0]                     invalidate_addr,
  output logic [ID_WIDTH-1:0]                       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                     m_axi_awaddr,
  output logic [7:0]                                m_axi_awlen,
  output logic [2:0]                                m_axi_awsize,
  output logic [1:0]                                m_axi_awburst,
  output logic                                      m_axi_awlock,
  output logic [3:0]                                m_axi_awcache,
  output logic [2:0]                                m_axi_awprot,
  output logic                                      m_axi_awvalid,
  input  logic                                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]                     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                   m_axi_wstrb,
  output logic                                      m_axi_wlast,
  output logic                                      m_axi_wvalid,
  input  logic                                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]                       m_axi_bid,
  input  logic [1:0]                                m_axi_bresp,
  input  logic                                      m_axi_bvalid,
  output logic                                      m_axi_bready,
  output logic [ID_WIDTH-1:0]                       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                     m_axi_araddr,
  output logic [7:0]                                m_axi_arlen,
  output logic [2:0]                                m_axi_arsize,
  output logic [1:0]                                m_axi_arburst,
  output logic                                      m_axi_arlock,
  output logic [3:0]                                m_axi_arcache,
  output logic [2:0]                                m_axi_arprot,
  output logic                                      m_axi_arvalid,
  input  logic                                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]                       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                     m_axi_rdata,
  input  logic [1:0]                                m_axi_rresp,
  input  logic                                      m_axi_rlast,
  input  logic                                      m_axi_rvalid,
  output logic                                      m_axi_rready,
  input  logic                                      m_axi_acvalid,
  output logic                                      m_axi_acready,
  input  logic [ADDR_WIDTH-1:0]                     m_axi_acaddr,
  input  logic [3:0]                                m_axi_acsnoop
);

  localparam int unsigned LW  = DATA_WIDTH * LINE_BEATS;
  localparam int unsigned OFF = $clog2(LW / 8);
  localparam int unsigned BW  = $clog2(LINE_BEATS);
  localparam int unsigned CW  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;

  bus_state_e state_q, state_d;

  logic [CW-1:0]         client_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         line_q;
  logic [BW-1:0]         beat_q;
  logic                  inv_q;
  logic [ADDR_WIDTH-1:0] inv_addr_q;

  logic [N_CLIENTS-1:0] grant;
  logic [CW-1:0]        grant_idx;
  logic                 any_req;
  logic                 accept, r_hs, w_hs, last_beat;
  logic                 unused_resp;

  bus_arbiter #(
    .N_CLIENTS(N_CLIENTS),
    .IDX_WIDTH(CW)
  ) u_arbiter (
    .req      (command_valid),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_req  (any_req)
  );

  assign accept    = (state_q == StIdle) && any_req;
  assign r_hs      = (state_q == StR) && m_axi_rvalid;
  assign w_hs      = (state_q == StW) && m_axi_wready;
  assign last_beat = (beat_q == BW'(LINE_BEATS - 1));

  // Response codes, IDs and snoop type carry no information this master acts on.
  assign unused_resp = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp, m_axi_acsnoop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = command_store[grant_idx] ? StAw : StAr;
      StAr:    if (m_axi_arready) state_d = StR;
      StR:     if (m_axi_rvalid && m_axi_rlast) state_d = StDone;
      StAw:    if (m_axi_awready) state_d = StW;
      StW:     if (w_hs && last_beat) state_d = StB;
      StB:     if (m_axi_bvalid) state_d = StDone;
      StDone:  if (command_rready[client_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_ready     = (state_q == StIdle) ? grant : '0;
    bus_valid     = '0;
    if (state_q == StDone) bus_valid[client_q] = 1'b1;
    m_axi_arvalid = (state_q == StAr);
    m_axi_rready  = (state_q == StR);
    m_axi_awvalid = (state_q == StAw);
    m_axi_wvalid  = (state_q == StW);
    m_axi_wlast   = (state_q == StW) && last_beat;
    m_axi_bready  = (state_q == StB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      client_q <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      beat_q   <= '0;
    end else if (accept) begin
      client_q <= grant_idx;
      addr_q   <= command_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] & LINE_MASK;
      line_q   <= command_store[grant_idx] ? data_in[grant_idx*LW +: LW] : '0;
      beat_q   <= '0;
    end else if (r_hs) begin
      line_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
      beat_q <= beat_q + 1'b1;
    end else if (w_hs) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Snoops are accepted every cycle and never interact with the burst FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      inv_q <= m_axi_acvalid;
      if (m_axi_acvalid) inv_addr_q <= m_axi_acaddr & LINE_MASK;
    end
  end

  assign data_out        = line_q;
  assign invalidate      = inv_q;
  assign invalidate_addr = inv_addr_q;
  assign m_axi_acready   = 1'b1;

  assign m_axi_wdata = line_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign m_axi_wstrb = '1;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = LEN_LINE;
  assign m_axi_awsize  = SIZE_8B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot  = '0;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = LEN_LINE;
  assign m_axi_arsize  = SIZE_8B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot  = '0;

endmodule

// File: tb/tb_cache_memory_bus.sv
// Bench for cache_memory_bus: inline AXI slave, vector table of line transactions,
// scoreboard queue of expected completions, plus arbitration, snoop and reset sequences.
module tb_cache_memory_bus;

  localparam int N   = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LB  = 16;
  localparam int LW  = DW * LB;
  localparam int IDW = 13;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    command_valid, command_store, command_rready;
  logic [N*AW-1:0] command_addr;
  logic [N*LW-1:0] data_in;
  logic [N-1:0]    bus_ready, bus_valid;
  logic [LW-1:0]   data_out;
  logic            invalidate;
  logic [AW-1:0]   invalidate_addr;

  logic [IDW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0]  m_axi_awaddr, m_axi_araddr, m_axi_acaddr;
  logic [7:0]     m_axi_awlen, m_axi_arlen;
  logic [2:0]     m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]     m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic           m_axi_awlock, m_axi_arlock;
  logic [3:0]     m_axi_awcache, m_axi_arcache, m_axi_acsnoop;
  logic           m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]  m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic           m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready, m_axi_acvalid, m_axi_acready;

  cache_memory_bus dut (
    .clk(clk), .reset(reset),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr), .data_in(data_in),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .data_out(data_out),
    .invalidate(invalidate), .invalidate_addr(invalidate_addr),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_acvalid(m_axi_acvalid),
    .m_axi_acready(m_axi_acready), .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          client;
    bit          store;
    logic [63:0] addr;
    logic [63:0] pat;
    int          wgap;
    int          lat;
    int          snoop_beat;
  } vec_t;

  typedef struct {
    int            client;
    bit            chk_data;
    logic [LW-1:0] line;
  } exp_t;

  vec_t vecs[4];
  exp_t sbq[$];
  int   checks, failures;

  function automatic logic [63:0] oh(input int c);
    oh = 64'd1 << c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = LB - 1; k >= 0; k--) if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s word %0d: got %h, want %h", name, bad, act[bad*DW +: DW],
               exp[bad*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; samples at posedge+2.
  task automatic txn(input int c, input bit st, input logic [63:0] addr, input logic [63:0] pat,
                     input int wgap, input int lat, input int snoop_beat, output int gw);
    logic [LW-1:0] line;
    logic [63:0]   exp_addr;
    exp_t          e;
    int            t0, n, k, errs, lastbad;
    exp_addr = addr & ~64'h7F;
    for (int j = 0; j < LB; j++) line[j*DW +: DW] = pat + 64'(j);
    command_store[c]         = st;
    command_addr[c*AW +: AW] = addr;
    data_in[c*LW +: LW]      = st ? line : ~line;
    command_valid[c]         = 1'b1;
    #1;
    gw = 0;
    while (bus_ready[c] !== 1'b1 && gw < 100) begin step(); #1; gw++; end
    chk($sformatf("bus_ready c%0d", c), 64'(bus_ready), oh(c));
    if (bus_ready[c] !== 1'b1) begin
      command_valid[c] = 1'b0;
      return;
    end
    t0 = cyc;
    e.client = c; e.chk_data = !st; e.line = line;
    sbq.push_back(e);
    step();
    command_valid[c] = 1'b0;
    #1;
    if (!st) begin
      n = 0;
      while (m_axi_arvalid !== 1'b1 && n < 50) begin step(); #1; n++; end
      chk("araddr", m_axi_araddr, exp_addr);
      chk("ar fields", 64'({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                            m_axi_arcache, m_axi_arprot, m_axi_arid}),
          64'({8'd15, 3'b011, 2'b01, 1'b0, 4'd0, 3'd0, 13'd0}));
      m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0;
      #1;
      errs = 0;
      for (int b = 0; b < LB; b++) begin
        if (m_axi_rready !== 1'b1) errs++;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pat + 64'(b);
        m_axi_rlast  = (b == LB - 1);
        if (b == snoop_beat) begin m_axi_acvalid = 1'b1; m_axi_acaddr = 64'h2345; end
        step();
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_acvalid = 1'b0;
        #1;
        if (b == snoop_beat) begin
          chk("invalidate pulse", 64'(invalidate), 64'd1);
          chk("invalidate_addr", invalidate_addr, 64'h2300);
        end
        if (snoop_beat >= 0 && b == snoop_beat + 1)
          chk("invalidate one cycle", 64'(invalidate), 64'd0);
      end
      chk("rready in R", 64'(errs), 64'd0);
    end else begin
      n = 0;
      while (m_axi_awvalid !== 1'b1 && n < 50) begin step(); #1; n++; end
      chk("awaddr", m_axi_awaddr, exp_addr);
      chk("aw fields", 64'({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                            m_axi_awcache, m_axi_awprot, m_axi_awid}),
          64'({8'd15, 3'b011, 2'b01, 1'b0, 4'd0, 3'd0, 13'd0}));
      m_axi_awready = 1'b1;
      step();
      m_axi_awready = 1'b0;
      #1;
      k = 0; errs = 0; lastbad = 0; n = 0;
      while (k < LB && n < 200) begin
        m_axi_wready = (wgap == 0) ? 1'b1 : (n % 2 == 0);
        if (m_axi_wvalid !== 1'b1 || m_axi_wstrb !== 8'hFF) errs++;
        if (m_axi_wdata !== line[k*DW +: DW]) errs++;
        if (m_axi_wready) begin
          if (m_axi_wlast !== (k == LB - 1)) lastbad++;
          k++;
        end
        step();
        m_axi_wready = 1'b0;
        #1;
        n++;
      end
      chk("w beat count", 64'(k), 64'(LB));
      chk("w beat data", 64'(errs), 64'd0);
      chk("wlast placement", 64'(lastbad), 64'd0);
      n = 0;
      while (m_axi_bready !== 1'b1 && n < 50) begin step(); #1; n++; end
      chk("bready", 64'(m_axi_bready), 64'd1);
      m_axi_bvalid = 1'b1;
      step();
      m_axi_bvalid = 1'b0;
      #1;
    end
    n = 0;
    while (bus_valid === '0 && n < 50) begin step(); #1; n++; end
    if (lat >= 0) chk("latency", 64'(cyc - t0), 64'(lat));
    if (sbq.size() == 0) begin
      chk("scoreboard empty", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    chk("bus_valid", 64'(bus_valid), oh(e.client));
    if (e.chk_data) chk_line("data_out", data_out, e.line);
    step(); step(); #1;
    chk("bus_valid held", 64'(bus_valid), oh(e.client));
    if (e.chk_data) chk_line("data_out held", data_out, e.line);
    command_rready[c] = 1'b1;
    step();
    command_rready[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gw;
    command_valid = '0; command_store = '0; command_rready = '0;
    command_addr = '0; data_in = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_rvalid = 0; m_axi_acvalid = 0; m_axi_acaddr = '0; m_axi_acsnoop = '0;
    reset = 1'b0;

    vecs[0] = '{client: 0, store: 0, addr: 64'h1000_0047, pat: 64'h0, wgap: 0, lat: 18,
                snoop_beat: 5};
    vecs[1] = '{client: 1, store: 1, addr: 64'h80, pat: 64'hA0, wgap: 1, lat: -1,
                snoop_beat: -1};
    vecs[2] = '{client: 1, store: 0, addr: 64'hFFFF_FFFF_FFFF_FFFF, pat: 64'hDEAD_0000,
                wgap: 0, lat: 18, snoop_beat: -1};
    vecs[3] = '{client: 0, store: 1, addr: 64'h1234_5678, pat: 64'h5000, wgap: 0, lat: 19,
                snoop_beat: -1};

    repeat (3) @(posedge clk);
    #2;
    chk("reset bus_valid", 64'(bus_valid), 64'd0);
    chk("reset bus_ready", 64'(bus_ready), 64'd0);
    chk("reset axi valids", 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
                                 m_axi_bready}), 64'd0);
    chk("reset invalidate", 64'(invalidate), 64'd0);
    chk_line("reset data_out", data_out, '0);
    chk("acready tied", 64'(m_axi_acready), 64'd1);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      txn(vecs[i].client, vecs[i].store, vecs[i].addr, vecs[i].pat, vecs[i].wgap, vecs[i].lat,
          vecs[i].snoop_beat, gw);
      chk($sformatf("vec%0d grant wait", i), 64'(gw), 64'd0);
    end

    // Both clients request together: data cache first, icache on the next IDLE cycle.
    command_store[1] = 1'b0;
    command_addr[AW +: AW] = 64'h4000;
    command_valid[1] = 1'b1;
    txn(0, 0, 64'h3000_0010, 64'h300, 0, 18, -1, gw);
    chk("arb c0 first", 64'(gw), 64'd0);
    txn(1, 0, 64'h4000, 64'h400, 0, 18, -1, gw);
    chk("arb c1 next idle", 64'(gw), 64'd0);

    // Reset in the middle of a refill at beat 7.
    command_store[0] = 1'b0;
    command_addr[0 +: AW] = 64'h5000;
    command_valid[0] = 1'b1;
    #1;
    chk("rst-seq grant", 64'(bus_ready), 64'd1);
    step();
    command_valid[0] = 1'b0;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'h7700 + 64'(b);
      step();
    end
    m_axi_rdata = 64'h7707;
    reset = 1'b0;
    #1;
    chk("mid-burst reset rready", 64'(m_axi_rready), 64'd0);
    chk("mid-burst reset valids", 64'({bus_valid, bus_ready, m_axi_arvalid, m_axi_awvalid,
                                       m_axi_wvalid, m_axi_bready, invalidate}), 64'd0);
    chk_line("mid-burst reset data_out", data_out, '0);
    step();
    m_axi_rvalid = 1'b0;
    reset = 1'b1;
    step();
    txn(1, 0, 64'h6000, 64'h600, 0, 18, -1, gw);
    chk("post-reset grant wait", 64'(gw), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
